uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Sequencer/config owner for the UART RX core: tracks each frame from start edge to close, drops errored frames,
//  buffers good bytes in a FIFO with valid/ready drain, keeps saturating error counters, applies new
//  prescale/parity config only between frames. Sits between the RX core and the system register/control logic.
// PARAMETERS
//  DATA_WIDTH   8  byte width, matches RX core P_DATA
//  FIFO_DEPTH   4  good-byte buffer entries, power of 2, >=2
//  CNT_WIDTH    8  width of each saturating error counter
//  PRESCALE_RST 8  prescale driven to RX core out of reset
// PORTS
//  clk_RX        in   1   receiver clock, all logic on rising edge
//  rst           in   1   async active-high reset
//  RX_IN         in   1   serial line (already synchronised), watched for start edge
//  data_Valid    in   1   RX core: frame accepted, P_DATA valid this cycle
//  P_DATA        in   8   RX core parallel byte
//  Parity_Error  in   1   RX core error flags; any high in FRAME = frame failure
//  Stop_Error    in   1
//  str_glitch    in   1
//  cfg_wr        in   1   1-cycle request to load new config
//  cfg_prescale  in   6   requested prescale (8/16/32 valid; others ignored, cfg_err pulse)
//  cfg_par_en    in   1   requested parity enable
//  cfg_par_typ   in   1   requested parity type
//  prescale      out  6   applied to RX core
//  PAR_EN        out  1   applied to RX core
//  PAR_TYP       out  1   applied to RX core
//  rd_data       out  8   FIFO head byte
//  rd_valid      out  1   FIFO not empty
//  rd_ready      in   1   consumer pop; pop when rd_valid&&rd_ready
//  rx_busy       out  1   high in FRAME state
//  cfg_pending   out  1   config write waiting for idle
//  cfg_err       out  1   1-cycle pulse on illegal cfg_prescale
//  par_err_cnt   out  CNT_WIDTH  saturating count of parity failures
//  stp_err_cnt   out  CNT_WIDTH  saturating count of stop failures
//  glitch_cnt    out  CNT_WIDTH  saturating count of start glitches
//  ovr_cnt       out  CNT_WIDTH  saturating count of good bytes dropped (FIFO full) or frame timeouts
// BEHAVIOUR
//  Reset: prescale=PRESCALE_RST, PAR_EN=0, PAR_TYP=0, FIFO empty, rd_valid=0, rd_data=0, counters 0,
//   rx_busy=0, cfg_pending=0, cfg_err=0, FSM=IDLE. Reset mid-frame discards frame and any pending config.
//  FSM IDLE: RX_IN 1->0 (registered prev value) -> FRAME, timer cleared.
//   Else if cfg_pending -> load shadow into prescale/PAR_EN/PAR_TYP next edge, clear cfg_pending.
//   Falling edge and pending apply in same cycle: edge wins, config stays pending.
//  FSM FRAME: timer counts each cycle. Close on first of:
//   data_Valid with no error flag -> push P_DATA; any error flag -> drop, bump matching counter(s)
//   (several flags same cycle bump each); timer == prescale*12 -> drop, bump ovr_cnt. Close -> IDLE.
//   data_Valid and error flag same cycle: treated as error, byte dropped.
//  Timer 10 bits (max 63*12=756); multiply done at config apply, held in register.
//  cfg_wr: legal value -> shadow overwritten (last write wins), cfg_pending=1; applied within 1 cycle
//   if IDLE, else after frame closes. Illegal prescale -> whole write ignored, cfg_err pulses next cycle.
//  FIFO: push and pop same cycle when full -> both accepted, count unchanged. Push when full and no pop
//   -> byte dropped, ovr_cnt++. rd_data first-word-fall-through, 0 latency from write to rd_valid+1 cycle.
//  Counters saturate at all-ones, never wrap.
//  Latency: data_Valid edge -> rd_valid high next cycle (empty FIFO).
// STRUCTURE
//  Shared package uart_rx_pkg: FSM state encodings (IDLE, FRAME), legal prescale constants, FRAME_BITS_MAX=12.
//  One sub-module: uart_rx_byte_fifo (sync FIFO, DATA_WIDTH x FIFO_DEPTH, full/empty, FWFT).
//  FSM, timer, config shadow, counters in this module.
// TESTING
//  Good frame: RX_IN low, data_Valid with P_DATA=0xA5, rd_ready=0 -> rd_valid=1, rd_data=0xA5 next cycle, counters 0.
//  Parity_Error=1 at close, PAR_EN=1 -> no push, par_err_cnt=1; 300 such -> par_err_cnt saturates at 255.
//  5 good frames, rd_ready=0, DEPTH=4 -> 4 bytes held in order, ovr_cnt=1; then pop+push same cycle on full accepted.
//  cfg_wr prescale=16 mid-frame -> cfg_pending=1, prescale stays 8 until data_Valid, updates next IDLE cycle.
//  cfg_wr prescale=12 -> cfg_err pulse, prescale/cfg_pending unchanged.
//  RX_IN held low, no data_Valid, prescale=8 -> FRAME exits after 96 cycles, ovr_cnt=1; rst mid-frame -> all reset values.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX frame controller: FSM states, legal prescales, config payload.
package uart_rx_pkg;

    localparam int unsigned PRESCALE_W     = 6;
    localparam int unsigned TIMER_W        = 10;
    localparam int unsigned FRAME_BITS_MAX = 12;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [PRESCALE_W-1:0] prescale;
        logic                  par_en;
        logic                  par_typ;
    } rx_cfg_t;

    // Only oversampling ratios the RX core supports are accepted.
    function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

    // Frame timeout in clocks: one full worst-case frame of bit periods.
    function automatic logic [TIMER_W-1:0] frame_limit(input logic [PRESCALE_W-1:0] p);
        return TIMER_W'(p) * TIMER_W'(FRAME_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Bus between the RX core / system side and the frame controller.
interface uart_rx_frame_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                  RX_IN;
    logic                  data_Valid;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Parity_Error;
    logic                  Stop_Error;
    logic                  str_glitch;
    logic                  cfg_wr;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic                  cfg_par_en;
    logic                  cfg_par_typ;
    logic [PRESCALE_W-1:0] prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  rx_busy;
    logic                  cfg_pending;
    logic                  cfg_err;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stp_err_cnt;
    logic [CNT_WIDTH-1:0]  glitch_cnt;
    logic [CNT_WIDTH-1:0]  ovr_cnt;

    modport master (
        output RX_IN, data_Valid, P_DATA, Parity_Error, Stop_Error, str_glitch,
        output cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ, rd_ready,
        input  prescale, PAR_EN, PAR_TYP, rd_data, rd_valid, rx_busy, cfg_pending, cfg_err,
        input  par_err_cnt, stp_err_cnt, glitch_cnt, ovr_cnt
    );

    modport slave (
        input  RX_IN, data_Valid, P_DATA, Parity_Error, Stop_Error, str_glitch,
        input  cfg_wr, cfg_prescale, cfg_par_en, cfg_par_typ, rd_ready,
        output prescale, PAR_EN, PAR_TYP, rd_data, rd_valid, rx_busy, cfg_pending, cfg_err,
        output par_err_cnt, stp_err_cnt, glitch_cnt, ovr_cnt
    );

endinterface

// File: rtl/uart_rx_byte_fifo.sv
// Small synchronous first-word-fall-through FIFO for received good bytes.
module uart_rx_byte_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  push_ok_c;
    logic                  pop_ok_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign valid_o   = (count_q != '0);
    assign data_o    = mem_q[rd_ptr_q];
    assign pop_ok_c  = pop_i && valid_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok_c = push_i && (!full_o || pop_ok_c);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer and config owner for the UART RX core: frame tracking, error counters, byte buffering.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned PRESCALE_RST = 8
) (
    input  logic                  clk_RX,
    input  logic                  rst,
    uart_rx_frame_ctrl_if.slave   bus
);
    rx_state_e             state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [TIMER_W-1:0]    limit_q;
    logic                  rx_prev_q;
    rx_cfg_t               shadow_q;
    logic                  cfg_pending_q;
    logic                  cfg_err_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [CNT_WIDTH-1:0]  par_cnt_q, stp_cnt_q, glt_cnt_q, ovr_cnt_q;

    logic fall_edge_c, err_any_c, cfg_legal_c;
    logic push_c, apply_c, timeout_c;
    logic inc_par_c, inc_stp_c, inc_glt_c, inc_ovr_c;
    logic fifo_full_c, fifo_valid_c, pop_c, fifo_drop_c;

    assign fall_edge_c = rx_prev_q && !bus.RX_IN;
    assign err_any_c   = bus.Parity_Error || bus.Stop_Error || bus.str_glitch;
    assign cfg_legal_c = bus.cfg_wr && prescale_legal(bus.cfg_prescale);
    assign pop_c       = fifo_valid_c && bus.rd_ready;
    assign fifo_drop_c = push_c && fifo_full_c && !pop_c;
    assign inc_ovr_c   = timeout_c || fifo_drop_c;

    // FSM state register.
    always_ff @(posedge clk_RX or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state: open on start edge, close on good byte, error flag or timeout.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        push_c    = 1'b0;
        apply_c   = 1'b0;
        timeout_c = 1'b0;
        inc_par_c = 1'b0;
        inc_stp_c = 1'b0;
        inc_glt_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_edge_c) begin
                    state_d = ST_FRAME;
                    timer_d = '0;
                end else if (cfg_pending_q) begin
                    apply_c = 1'b1;
                end
            end
            ST_FRAME: begin
                timer_d = timer_q + TIMER_W'(1);
                if (err_any_c) begin
                    inc_par_c = bus.Parity_Error;
                    inc_stp_c = bus.Stop_Error;
                    inc_glt_c = bus.str_glitch;
                    state_d   = ST_IDLE;
                end else if (bus.data_Valid) begin
                    push_c  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_d == limit_q) begin
                    timeout_c = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line history, config shadow and applied config.
    always_ff @(posedge clk_RX or posedge rst) begin
        if (rst) begin
            rx_prev_q     <= 1'b1;
            shadow_q      <= '0;
            cfg_pending_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            prescale_q    <= PRESCALE_W'(PRESCALE_RST);
            limit_q       <= TIMER_W'(PRESCALE_RST * FRAME_BITS_MAX);
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
        end else begin
            rx_prev_q <= bus.RX_IN;
            cfg_err_q <= bus.cfg_wr && !cfg_legal_c;
            if (apply_c) begin
                prescale_q <= shadow_q.prescale;
                limit_q    <= frame_limit(shadow_q.prescale);
                par_en_q   <= shadow_q.par_en;
                par_typ_q  <= shadow_q.par_typ;
            end
            // A new legal write overrides an apply in the same cycle, so it stays pending.
            if (cfg_legal_c) begin
                shadow_q      <= '{prescale: bus.cfg_prescale, par_en: bus.cfg_par_en,
                                   par_typ: bus.cfg_par_typ};
                cfg_pending_q <= 1'b1;
            end else if (apply_c) begin
                cfg_pending_q <= 1'b0;
            end
        end
    end

    // Saturating error counters.
    always_ff @(posedge clk_RX or posedge rst) begin
        if (rst) begin
            par_cnt_q <= '0;
            stp_cnt_q <= '0;
            glt_cnt_q <= '0;
            ovr_cnt_q <= '0;
        end else begin
            if (inc_par_c && (par_cnt_q != '1)) par_cnt_q <= par_cnt_q + CNT_WIDTH'(1);
            if (inc_stp_c && (stp_cnt_q != '1)) stp_cnt_q <= stp_cnt_q + CNT_WIDTH'(1);
            if (inc_glt_c && (glt_cnt_q != '1)) glt_cnt_q <= glt_cnt_q + CNT_WIDTH'(1);
            if (inc_ovr_c && (ovr_cnt_q != '1)) ovr_cnt_q <= ovr_cnt_q + CNT_WIDTH'(1);
        end
    end

    uart_rx_byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_RX),
        .rst         (rst),
        .push_i      (push_c),
        .push_data_i (bus.P_DATA),
        .pop_i       (pop_c),
        .full_o      (fifo_full_c),
        .valid_o     (fifo_valid_c),
        .data_o      (bus.rd_data)
    );

    assign bus.rd_valid    = fifo_valid_c;
    assign bus.prescale    = prescale_q;
    assign bus.PAR_EN      = par_en_q;
    assign bus.PAR_TYP     = par_typ_q;
    assign bus.rx_busy     = (state_q == ST_FRAME);
    assign bus.cfg_pending = cfg_pending_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.par_err_cnt = par_cnt_q;
    assign bus.stp_err_cnt = stp_cnt_q;
    assign bus.glitch_cnt  = glt_cnt_q;
    assign bus.ovr_cnt     = ovr_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for the UART RX frame controller.
module tb_uart_rx_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

    uart_rx_frame_ctrl #(
        .DATA_WIDTH   (8),
        .FIFO_DEPTH   (4),
        .CNT_WIDTH    (8),
        .PRESCALE_RST (8)
    ) dut (
        .clk_RX (clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    task automatic idle_inputs();
        bus.RX_IN = 1'b1; bus.data_Valid = 1'b0; bus.P_DATA = 8'h00;
        bus.Parity_Error = 1'b0; bus.Stop_Error = 1'b0; bus.str_glitch = 1'b0;
        bus.cfg_wr = 1'b0; bus.cfg_prescale = 6'd0; bus.cfg_par_en = 1'b0; bus.cfg_par_typ = 1'b0;
        bus.rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One idle cycle with the line high, then a falling edge; returns in FRAME.
    task automatic start_frame();
        bus.RX_IN = 1'b1;
        @(negedge clk);
        bus.RX_IN = 1'b0;
        @(negedge clk);
    endtask

    task automatic close_frame(input logic dv, input logic [7:0] b, input logic pe,
                               input logic se, input logic gl, input logic rdy);
        bus.data_Valid = dv; bus.P_DATA = b;
        bus.Parity_Error = pe; bus.Stop_Error = se; bus.str_glitch = gl; bus.rd_ready = rdy;
        @(negedge clk);
        bus.data_Valid = 1'b0; bus.Parity_Error = 1'b0; bus.Stop_Error = 1'b0;
        bus.str_glitch = 1'b0; bus.rd_ready = 1'b0; bus.RX_IN = 1'b1;
    endtask

    task automatic cfg_write(input logic [5:0] p, input logic en, input logic typ);
        bus.cfg_wr = 1'b1; bus.cfg_prescale = p; bus.cfg_par_en = en; bus.cfg_par_typ = typ;
        @(negedge clk);
        bus.cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.prescale !== 6'd8) begin fails++; $display("FAIL reset_prescale: got %0d expected 8", bus.prescale); end
        tests++; if (bus.PAR_EN !== 1'b0 || bus.PAR_TYP !== 1'b0) begin fails++; $display("FAIL reset_parity_cfg: got %b%b expected 00", bus.PAR_EN, bus.PAR_TYP); end
        tests++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin fails++; $display("FAIL reset_fifo: got valid=%b data=%h expected 0/00", bus.rd_valid, bus.rd_data); end
        tests++; if ({bus.par_err_cnt, bus.stp_err_cnt, bus.glitch_cnt, bus.ovr_cnt} !== 32'h0) begin fails++; $display("FAIL reset_counters: got %h expected 0", {bus.par_err_cnt, bus.stp_err_cnt, bus.glitch_cnt, bus.ovr_cnt}); end
        tests++; if ({bus.rx_busy, bus.cfg_pending, bus.cfg_err} !== 3'b000) begin fails++; $display("FAIL reset_status: got %b expected 000", {bus.rx_busy, bus.cfg_pending, bus.cfg_err}); end
    endtask

    task automatic test_good_frame();
        do_reset();
        start_frame();
        tests++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL good_busy: got %b expected 1", bus.rx_busy); end
        close_frame(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin fails++; $display("FAIL good_byte: got valid=%b data=%h expected 1/a5", bus.rd_valid, bus.rd_data); end
        tests++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL good_close: got busy=%b expected 0", bus.rx_busy); end
        tests++; if ({bus.par_err_cnt, bus.stp_err_cnt, bus.glitch_cnt, bus.ovr_cnt} !== 32'h0) begin fails++; $display("FAIL good_counters: got %h expected 0", {bus.par_err_cnt, bus.stp_err_cnt, bus.glitch_cnt, bus.ovr_cnt}); end
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL good_pop: got valid=%b expected 0", bus.rd_valid); end
    endtask

    task automatic test_parity_errors();
        do_reset();
        cfg_write(6'd8, 1'b1, 1'b1);
        tests++; if (bus.cfg_pending !== 1'b1 || bus.PAR_EN !== 1'b0) begin fails++; $display("FAIL par_cfg_pending: got pend=%b en=%b expected 1/0", bus.cfg_pending, bus.PAR_EN); end
        @(negedge clk);
        tests++; if (bus.PAR_EN !== 1'b1 || bus.PAR_TYP !== 1'b1 || bus.cfg_pending !== 1'b0) begin fails++; $display("FAIL par_cfg_apply: got en=%b typ=%b pend=%b expected 1/1/0", bus.PAR_EN, bus.PAR_TYP, bus.cfg_pending); end
        start_frame();
        close_frame(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (bus.rd_valid !== 1'b0 || bus.par_err_cnt !== 8'd1 || bus.stp_err_cnt !== 8'd0) begin fails++; $display("FAIL par_first: got valid=%b par=%0d stp=%0d expected 0/1/0", bus.rd_valid, bus.par_err_cnt, bus.stp_err_cnt); end
        for (int i = 0; i < 299; i++) begin
            start_frame();
            close_frame(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tests++; if (bus.par_err_cnt !== 8'd255) begin fails++; $display("FAIL par_saturate: got %0d expected 255", bus.par_err_cnt); end
        start_frame();
        close_frame(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tests++; if (bus.stp_err_cnt !== 8'd1 || bus.glitch_cnt !== 8'd1 || bus.par_err_cnt !== 8'd255) begin fails++; $display("FAIL multi_err: got stp=%0d glt=%0d par=%0d expected 1/1/255", bus.stp_err_cnt, bus.glitch_cnt, bus.par_err_cnt); end
        start_frame();
        close_frame(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
        tests++; if (bus.stp_err_cnt !== 8'd2 || bus.glitch_cnt !== 8'd2 || bus.par_err_cnt !== 8'd255 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL all_err: got stp=%0d glt=%0d par=%0d valid=%b expected 2/2/255/0", bus.stp_err_cnt, bus.glitch_cnt, bus.par_err_cnt, bus.rd_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] in_b [5];
        logic [7:0] exp_b [4];
        in_b[0] = 8'h11; in_b[1] = 8'h22; in_b[2] = 8'h33; in_b[3] = 8'h44; in_b[4] = 8'h55;
        exp_b[0] = 8'h22; exp_b[1] = 8'h33; exp_b[2] = 8'h44; exp_b[3] = 8'h66;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            start_frame();
            close_frame(1'b1, in_b[i], 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tests++; if (bus.ovr_cnt !== 8'd1) begin fails++; $display("FAIL full_drop: got ovr=%0d expected 1", bus.ovr_cnt); end
        tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h11) begin fails++; $display("FAIL full_head: got valid=%b data=%h expected 1/11", bus.rd_valid, bus.rd_data); end
        start_frame();
        close_frame(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.ovr_cnt !== 8'd1) begin fails++; $display("FAIL full_pop_push: got ovr=%0d expected 1", bus.ovr_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_b[i]) begin fails++; $display("FAIL drain_%0d: got valid=%b data=%h expected 1/%h", i, bus.rd_valid, bus.rd_data, exp_b[i]); end
            bus.rd_ready = 1'b1;
            @(negedge clk);
            bus.rd_ready = 1'b0;
        end
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got valid=%b expected 0", bus.rd_valid); end
    endtask

    task automatic test_cfg_midframe();
        do_reset();
        start_frame();
        cfg_write(6'd16, 1'b0, 1'b0);
        tests++; if (bus.cfg_pending !== 1'b1 || bus.prescale !== 6'd8) begin fails++; $display("FAIL mid_pending: got pend=%b presc=%0d expected 1/8", bus.cfg_pending, bus.prescale); end
        repeat (3) @(negedge clk);
        tests++; if (bus.prescale !== 6'd8 || bus.rx_busy !== 1'b1) begin fails++; $display("FAIL mid_hold: got presc=%0d busy=%b expected 8/1", bus.prescale, bus.rx_busy); end
        close_frame(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (bus.prescale !== 6'd8 || bus.cfg_pending !== 1'b1) begin fails++; $display("FAIL mid_close: got presc=%0d pend=%b expected 8/1", bus.prescale, bus.cfg_pending); end
        @(negedge clk);
        tests++; if (bus.prescale !== 6'd16 || bus.cfg_pending !== 1'b0) begin fails++; $display("FAIL mid_apply: got presc=%0d pend=%b expected 16/0", bus.prescale, bus.cfg_pending); end
    endtask

    task automatic test_cfg_illegal();
        do_reset();
        cfg_write(6'd12, 1'b1, 1'b1);
        tests++; if (bus.cfg_err !== 1'b1 || bus.cfg_pending !== 1'b0 || bus.prescale !== 6'd8) begin fails++; $display("FAIL illegal_pulse: got err=%b pend=%b presc=%0d expected 1/0/8", bus.cfg_err, bus.cfg_pending, bus.prescale); end
        @(negedge clk);
        tests++; if (bus.cfg_err !== 1'b0 || bus.PAR_EN !== 1'b0 || bus.prescale !== 6'd8) begin fails++; $display("FAIL illegal_after: got err=%b en=%b presc=%0d expected 0/0/8", bus.cfg_err, bus.PAR_EN, bus.prescale); end
    endtask

    task automatic test_edge_vs_apply();
        do_reset();
        bus.cfg_wr = 1'b1; bus.cfg_prescale = 6'd32;
        @(negedge clk);
        bus.cfg_wr = 1'b0; bus.RX_IN = 1'b0;
        @(negedge clk);
        tests++; if (bus.rx_busy !== 1'b1 || bus.cfg_pending !== 1'b1 || bus.prescale !== 6'd8) begin fails++; $display("FAIL edge_wins: got busy=%b pend=%b presc=%0d expected 1/1/8", bus.rx_busy, bus.cfg_pending, bus.prescale); end
        close_frame(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tests++; if (bus.prescale !== 6'd32 || bus.cfg_pending !== 1'b0 || bus.rd_data !== 8'h3C) begin fails++; $display("FAIL edge_then_apply: got presc=%0d pend=%b data=%h expected 32/0/3c", bus.prescale, bus.cfg_pending, bus.rd_data); end
    endtask

    task automatic test_timeout_and_reset();
        int busy_cycles;
        do_reset();
        bus.RX_IN = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.rx_busy) busy_cycles++;
            else break;
        end
        tests++; if (busy_cycles !== 96) begin fails++; $display("FAIL timeout_len: got %0d busy cycles expected 96", busy_cycles); end
        tests++; if (bus.ovr_cnt !== 8'd1 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL timeout_ovr: got ovr=%0d valid=%b expected 1/0", bus.ovr_cnt, bus.rd_valid); end
        start_frame();
        cfg_write(6'd32, 1'b1, 1'b0);
        tests++; if (bus.cfg_pending !== 1'b1 || bus.rx_busy !== 1'b1) begin fails++; $display("FAIL rst_setup: got pend=%b busy=%b expected 1/1", bus.cfg_pending, bus.rx_busy); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.rx_busy !== 1'b0 || bus.cfg_pending !== 1'b0 || bus.ovr_cnt !== 8'd0 || bus.prescale !== 6'd8) begin fails++; $display("FAIL rst_midframe: got busy=%b pend=%b ovr=%0d presc=%0d expected 0/0/0/8", bus.rx_busy, bus.cfg_pending, bus.ovr_cnt, bus.prescale); end
        @(negedge clk);
        rst = 1'b0; bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bus.prescale !== 6'd8 || bus.PAR_EN !== 1'b0 || bus.cfg_pending !== 1'b0) begin fails++; $display("FAIL rst_discard_cfg: got presc=%0d en=%b pend=%b expected 8/0/0", bus.prescale, bus.PAR_EN, bus.cfg_pending); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_good_frame();
        test_parity_errors();
        test_back_to_back();
        test_cfg_midframe();
        test_cfg_illegal();
        test_edge_vs_apply();
        test_timeout_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
